// File: rtl/data_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data RAM.
// The RAM reads combinationally and writes a whole word in one cycle.
// m0 is the CPU data port, m1 the loader/debug port. Partial-lane writes
// become a read-modify-write (grant cycle, RMW_RD, RMW_WR).
// Optional statistics counters: define DATA_RAM_ARB_STATS_EN.
module data_ram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter bit RR_INIT    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [31:0]           m0_writedata,
    input  logic [3:0]            m0_byteenable,
    output logic [31:0]           m0_readdata,
    output logic                  m0_waitrequest,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [31:0]           m1_writedata,
    input  logic [3:0]            m1_byteenable,
    output logic [31:0]           m1_readdata,
    output logic                  m1_waitrequest,
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [31:0]           s_writedata,
    input  logic [31:0]           s_readdata
`ifdef DATA_RAM_ARB_STATS_EN
    ,
    output logic [31:0]           grant_cnt_m0,
    output logic [31:0]           grant_cnt_m1,
    output logic [31:0]           conflict_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // master granted most recently
    logic [31:0] rmw_word_q, rmw_word_d;

    logic                  req0, req1, sel, done, rd_ok;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic                  g_read, g_write;
    logic [31:0]           g_wdata, lane_mask, merged;
    logic [3:0]            g_be;

    // State registers; everything returns to IDLE so an interrupted RMW never writes.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ~RR_INIT;
            rmw_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rmw_word_q   <= rmw_word_d;
        end
    end

    // Arbitration, RAM bus mux, RMW sequencing and master handshakes.
    // NOTE: every signal gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        rmw_word_d     = rmw_word_q;
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        done           = 1'b0;
        rd_ok          = 1'b0;

        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;

        // In IDLE pick a requester (alternate on conflict); otherwise stay locked.
        if (state_q == IDLE) sel = (req0 && req1) ? ~last_grant_q : req1;
        else                 sel = last_grant_q;

        g_addr  = sel ? m1_address    : m0_address;
        g_read  = sel ? m1_read       : m0_read;
        g_write = sel ? m1_write      : m0_write;
        g_wdata = sel ? m1_writedata  : m0_writedata;
        g_be    = sel ? m1_byteenable : m0_byteenable;

        lane_mask = {{8{g_be[3]}}, {8{g_be[2]}}, {8{g_be[1]}}, {8{g_be[0]}}};
        merged    = (s_readdata & ~lane_mask) | (g_wdata & lane_mask);

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        last_grant_d = sel;
                        s_address    = g_addr & WORD_MASK;
                        if (g_write && g_be != 4'h0 && g_be != 4'hF) begin
                            s_read     = 1'b1;
                            rmw_word_d = merged;
                            state_d    = RMW_RD;
                        end else begin
                            s_read      = g_read & ~g_write;
                            s_write     = g_write & (g_be != 4'h0);
                            s_writedata = g_write ? g_wdata : 32'h0;
                            rd_ok       = g_read & ~g_write;
                            done        = 1'b1;
                        end
                    end
                end
                RMW_RD: begin
                    s_address  = g_addr & WORD_MASK;
                    s_read     = 1'b1;
                    rmw_word_d = merged;
                    state_d    = RMW_WR;
                end
                RMW_WR: begin
                    s_address   = g_addr & WORD_MASK;
                    s_write     = 1'b1;
                    s_writedata = rmw_word_q;
                    done        = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (done) begin
            if (sel) begin
                m1_waitrequest = 1'b0;
                m1_readdata    = rd_ok ? s_readdata : 32'h0;
            end else begin
                m0_waitrequest = 1'b0;
                m0_readdata    = rd_ok ? s_readdata : 32'h0;
            end
        end
    end

`ifdef DATA_RAM_ARB_STATS_EN
    logic [31:0] grant_cnt_m0_q, grant_cnt_m0_d;
    logic [31:0] grant_cnt_m1_q, grant_cnt_m1_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    // Count completed accesses per master and IDLE cycles with both requesting.
    always_comb begin
        grant_cnt_m0_d = grant_cnt_m0_q + {31'b0, ~m0_waitrequest};
        grant_cnt_m1_d = grant_cnt_m1_q + {31'b0, ~m1_waitrequest};
        conflict_cnt_d = conflict_cnt_q
                       + {31'b0, (state_q == IDLE) && req0 && req1 && !reset};
    end

    // Statistics counter registers (wrap naturally at 2^32).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt_m0_q <= '0;
            grant_cnt_m1_q <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_m0_q <= grant_cnt_m0_d;
            grant_cnt_m1_q <= grant_cnt_m1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt_m0 = grant_cnt_m0_q;
    assign grant_cnt_m1 = grant_cnt_m1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: behavioural RAM, reference memory
// model and per-master read-data scoreboards. Stats checks run when
// DATA_RAM_ARB_STATS_EN is defined.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write;
`ifdef DATA_RAM_ARB_STATS_EN
    logic [31:0] grant_cnt_m0, grant_cnt_m1, conflict_cnt;
`endif

    logic [31:0] ram   [0:255];
    logic [31:0] model [0:255];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic        preload;
    int          write_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic        obs_sr, obs_sw;
    logic [31:0] obs_sa;

    data_ram_arbiter #(.ADDR_WIDTH(32), .RR_INIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata)
`ifdef DATA_RAM_ARB_STATS_EN
        , .grant_cnt_m0(grant_cnt_m0), .grant_cnt_m1(grant_cnt_m1),
        .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 2) ? 32'hAABBCCDD : {b, 8'hC3, ~b, 8'h3C};
    endfunction

    function automatic logic [31:0] merge_model(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // Behavioural RAM: combinational read, word write on the clock edge.
    assign s_readdata = ram[s_address[9:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= pattern(i);
        end else if (s_write) begin
            ram[s_address[9:2]] <= s_writedata;
            write_cnt <= write_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one request; reads push their expected data, writes update the model.
    task automatic issue(input int n, input logic [31:0] addr, input logic rd,
                         input logic wr, input logic [31:0] wd, input logic [3:0] be);
        logic [7:0] idx;
        idx = addr[9:2];
        if (rd && !wr) begin
            if (n == 0) exp_q0.push_back(model[idx]);
            else        exp_q1.push_back(model[idx]);
        end
        if (wr) model[idx] = merge_model(model[idx], wd, be);
        if (n == 0) begin
            m0_address = addr; m0_read = rd; m0_write = wr;
            m0_writedata = wd; m0_byteenable = be;
        end else begin
            m1_address = addr; m1_read = rd; m1_write = wr;
            m1_writedata = wd; m1_byteenable = be;
        end
    endtask

    // One clock: sample at negedge, score completions, drop finished requests.
    task automatic step(output bit d0, output bit d1);
        @(negedge clk);
        d0 = !m0_waitrequest;
        d1 = !m1_waitrequest;
        obs_sr = s_read;
        obs_sw = s_write;
        obs_sa = s_address;
        if (d0 && m0_read && !m0_write) begin
            check("m0 scoreboard has entry", {31'b0, exp_q0.size() != 0}, 32'd1);
            if (exp_q0.size() != 0) check("m0 readdata", m0_readdata, exp_q0.pop_front());
        end else if (!d0) begin
            check("m0 readdata while waiting", m0_readdata, 32'h0);
        end
        if (d1 && m1_read && !m1_write) begin
            check("m1 scoreboard has entry", {31'b0, exp_q1.size() != 0}, 32'd1);
            if (exp_q1.size() != 0) check("m1 readdata", m1_readdata, exp_q1.pop_front());
        end else if (!d1) begin
            check("m1 readdata while waiting", m1_readdata, 32'h0);
        end
        sync();
        if (d0) begin m0_read = 1'b0; m0_write = 1'b0; end
        if (d1) begin m1_read = 1'b0; m1_write = 1'b0; end
    endtask

    initial begin
        bit d0, d1;
        int wc;

        reset = 1'b1;
        preload = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = pattern(i);
        m0_address = '0; m0_read = 1'b1; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = 4'hF;
        m1_address = 32'h4; m1_read = 1'b0; m1_write = 1'b1; m1_writedata = 32'h1; m1_byteenable = 4'hF;

        // Requests during reset must be held off completely.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset m0_waitrequest", {31'b0, m0_waitrequest}, 32'd1);
        check("reset m1_waitrequest", {31'b0, m1_waitrequest}, 32'd1);
        check("reset s_read", {31'b0, s_read}, 32'd0);
        check("reset s_write", {31'b0, s_write}, 32'd0);
        check("reset m0_readdata", m0_readdata, 32'h0);
        check("reset m1_readdata", m1_readdata, 32'h0);
        m0_read = 1'b0; m1_write = 1'b0;
        preload = 1'b0;
        reset = 1'b0;

        @(negedge clk);
        check("idle s_address", s_address, 32'h0);
        check("idle s_writedata", s_writedata, 32'h0);
        check("idle s_read", {31'b0, s_read}, 32'd0);
        check("idle waitrequests", {30'b0, m0_waitrequest, m1_waitrequest}, 32'd3);

        // Full-write conflict after reset: m0 first; m0 re-requests back-to-back.
        sync();
        issue(0, 32'h10, 1'b0, 1'b1, 32'h11111111, 4'hF);
        issue(1, 32'h14, 1'b0, 1'b1, 32'h22222222, 4'hF);
        step(d0, d1);
        check("conflict1 grant", {30'b0, d0, d1}, 32'b10);
        issue(0, 32'h18, 1'b0, 1'b1, 32'h33333333, 4'hF);
        step(d0, d1);
        check("conflict2 grant (m1 wins)", {30'b0, d0, d1}, 32'b01);
        step(d0, d1);
        check("conflict2 m0 follows", {30'b0, d0, d1}, 32'b10);
        check("ram[4]", ram[4], model[4]);
        check("ram[5]", ram[5], model[5]);
        check("ram[6]", ram[6], model[6]);

        // Solo m0 read of word 0x8.
        issue(0, 32'h8, 1'b1, 1'b0, 32'h0, 4'hF);
        step(d0, d1);
        check("solo read completes", {30'b0, d0, d1}, 32'b10);
        check("solo read s_address", obs_sa, 32'h8);

        // Read conflict: last grant was m0, so m1 goes first.
        issue(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'hF);
        issue(1, 32'h16, 1'b1, 1'b0, 32'h0, 4'hF);
        step(d0, d1);
        check("read conflict m1 first", {30'b0, d0, d1}, 32'b01);
        check("unaligned address masked", obs_sa, 32'h14);
        step(d0, d1);
        check("read conflict m0 second", {30'b0, d0, d1}, 32'b10);

        // m1 partial write; m0 read to the same word arrives during RMW.
        issue(1, 32'h8, 1'b0, 1'b1, 32'h11223344, 4'b0101);
        step(d0, d1);
        check("rmw grant waits", {30'b0, d0, d1}, 32'b00);
        check("rmw grant s_rd/s_wr", {30'b0, obs_sr, obs_sw}, 32'b10);
        issue(0, 32'h8, 1'b1, 1'b0, 32'h0, 4'hF);
        step(d0, d1);
        check("rmw_rd both wait", {30'b0, d0, d1}, 32'b00);
        check("rmw_rd s_rd/s_wr", {30'b0, obs_sr, obs_sw}, 32'b10);
        step(d0, d1);
        check("rmw_wr m1 done", {30'b0, d0, d1}, 32'b01);
        check("rmw_wr s_rd/s_wr", {30'b0, obs_sr, obs_sw}, 32'b01);
        check("rmw ram word", ram[2], 32'hAA22CC44);
        step(d0, d1);
        check("held m0 read completes", {30'b0, d0, d1}, 32'b10);

        // Write with no lanes enabled: one cycle, no RAM write.
        wc = write_cnt;
        issue(0, 32'h8, 1'b0, 1'b1, 32'hFFFFFFFF, 4'h0);
        step(d0, d1);
        check("be0 completes", {30'b0, d0, d1}, 32'b10);
        check("be0 s_write", {31'b0, obs_sw}, 32'd0);
        check("be0 ram unchanged", ram[2], 32'hAA22CC44);
        check("be0 write count", write_cnt, wc);

        // Reset during RMW_RD of an m0 partial write: the write must never happen.
        wc = write_cnt;
        m0_address = 32'hC; m0_read = 1'b0; m0_write = 1'b1;
        m0_writedata = 32'h000000FF; m0_byteenable = 4'h1;
        step(d0, d1);
        check("pre-reset rmw grant waits", {31'b0, d0}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("mid-rmw reset waitrequests", {30'b0, m0_waitrequest, m1_waitrequest}, 32'd3);
        check("mid-rmw reset s_write", {31'b0, s_write}, 32'd0);
        sync();
        m0_write = 1'b0;
        @(negedge clk);
        check("mid-rmw reset s_write later", {31'b0, s_write}, 32'd0);
        reset = 1'b0;
        repeat (3) step(d0, d1);
        check("interrupted rmw write count", write_cnt, wc);
        check("interrupted rmw ram", ram[3], model[3]);

`ifdef DATA_RAM_ARB_STATS_EN
        reset = 1'b1;
        sync();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            issue(0, 32'h0, 1'b1, 1'b0, 32'h0, 4'hF);
            issue(1, 32'h4, 1'b1, 1'b0, 32'h0, 4'hF);
            step(d0, d1);
            step(d0, d1);
        end
        issue(0, 32'h8, 1'b1, 1'b0, 32'h0, 4'hF);
        step(d0, d1);
        check("conflict_cnt", conflict_cnt, 32'd3);
        check("grant_cnt_m0", grant_cnt_m0, 32'd4);
        check("grant_cnt_m1", grant_cnt_m1, 32'd3);
`endif

        check("scoreboards drained", exp_q0.size() + exp_q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
